r200_mem_arb: RTL and testbench
===============================

Name: r200_mem_arb

Overview:
- Arbiter for a single-ported unified memory shared by instruction fetch (IF) and the data-memory stage (MEM).
- One transaction is outstanding at a time. MEM normally wins; a starvation counter guarantees IF progress.
- Produces the per-stage stall signals that the pipeline registers and the pc controller consume.
- Sits between r200if/r200mem and the memory macro, replacing the private imem/dmem paths.

Parameters:
- AW, 32, address width
- DW, 32, data width
- STARVE_MAX, 4, consecutive MEM grants allowed while IF waits before IF is forced to win (1..15)
- TIMEOUT, 16, cycles to wait for m_rvalid before abort (used only with ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- if_req  in  1  IF read request; held until if_rvalid
- if_addr  in  AW  IF address
- if_gnt  out  1  one-cycle pulse when the IF request is issued to memory
- if_rvalid  out  1  one-cycle pulse when IF data is returned
- if_rdata  out  DW  IF read data; valid with if_rvalid, 0 otherwise
- d_req  in  1  MEM request; held until d_rvalid
- d_we  in  1  1 = write, 0 = read
- d_addr  in  AW  MEM address
- d_wdata  in  DW  MEM write data
- d_gnt  out  1  one-cycle issue pulse for MEM
- d_rvalid  out  1  one-cycle completion pulse for MEM (reads and writes)
- d_rdata  out  DW  MEM read data; 0 for writes and when d_rvalid is low
- m_req  out  1  memory request pulse
- m_we  out  1  memory write enable, qualified by m_req
- m_addr  out  AW  memory address, qualified by m_req
- m_wdata  out  DW  memory write data
- m_rdata  in  DW  memory read data
- m_rvalid  in  1  memory completion, one cycle, variable latency of at least 1 cycle after m_req
- stall_if  out  1  if_req & ~if_rvalid
- stall_mem  out  1  d_req & ~d_rvalid
- bus_err  out  1  timeout abort pulse; tied 0 without ARB_TIMEOUT_EN

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D. Reset state is IDLE, starvation count 0, timeout count 0.
- Outputs in reset: every output is 0, except stall_if and stall_mem, which follow the request inputs.
- IDLE with no request: outputs idle, state holds.
- IDLE, arbitration: when d_req=1 and (if_req=0 or starve<STARVE_MAX), MEM wins; else if if_req=1, IF wins.
- IDLE, issue on a win: gnt, m_req, m_we, m_addr and m_wdata are driven combinationally in the same cycle; next state is BUSY_x.
- Starvation counter:
  - Increments on each d_gnt while if_req=1.
  - Clears on if_gnt or whenever if_req=0.
  - Saturates at STARVE_MAX.
- BUSY_x: m_req=0.
  - When m_rvalid=1, x_rvalid=1 and x_rdata=m_rdata (combinational forward); next state is IDLE.
  - The next grant happens no earlier than the following cycle. Peak throughput is one transaction per (latency+1) cycles.
- m_rvalid in IDLE is ignored: no rvalid is pulsed. This covers late responses after reset.
- A requester that drops req while in BUSY is a protocol violation. The transaction still completes and its rvalid still pulses.
- Asserting rst mid-transaction forces IDLE immediately and drops the outstanding transaction. Any pending stalls remain asserted.
- Requester inputs are sampled only in IDLE. Address and data changes during BUSY have no effect.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - A counter runs in BUSY_x. When it reaches TIMEOUT cycles without m_rvalid, the arbiter pulses x_rvalid and bus_err for one cycle, drives x_rdata=32'h0000_0013 (NOP), and returns to IDLE.
  - A later stray m_rvalid is ignored.
- ARB_TIMEOUT_EN undefined: no counter, BUSY waits indefinitely, bus_err=0.

Decomposition:
- cpu.vh: state encodings (ARB_IDLE=2'd0, ARB_BUSY_I=2'd1, ARB_BUSY_D=2'd2) and the NOP constant.
- One sub-module, arb_starve_cnt: a saturating counter with inc, clr and sat outputs, parameterised by STARVE_MAX.

Test Plan:
- Lone IF read, addr 0x100, memory latency 2 → if_gnt in cycle 0; if_rvalid in cycle 2 with rdata=mem[0x100]; stall_if high in cycles 0-1.
- IF and MEM requesting in the same cycle, d_we=1, addr 0x200, data 0xCAFEF00D → d_gnt first, d_rvalid after latency, then if_gnt one cycle later; a later read of 0x200 returns 0xCAFEF00D.
- d_req held high continuously with if_req high, STARVE_MAX=4 → 4 d_gnt, then if_gnt, then the counter resets and MEM wins again.
- rst low during BUSY_D, then a stray m_rvalid after rst releases → no d_rvalid; state IDLE; next request is granted normally.
- ARB_TIMEOUT_EN, TIMEOUT=16, memory never responds → exactly 16 cycles after the grant: if_rvalid=1, if_rdata=0x00000013, bus_err=1 for one cycle.
- Back-to-back MEM reads with latency 1 → one grant every 2 cycles; gnt and rvalid are never high for both requesters in the same cycle.

Source files
------------

// File: rtl/r200_mem_arb_pkg.sv
// r200_mem_arb_pkg: shared types and constants for the unified-memory arbiter.
// State encodings match the legacy ARB_* values; ARB_NOP is returned on a
// timeout abort (ARB_TIMEOUT_EN builds only).
package r200_mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] ARB_NOP = 32'h0000_0013;

    // Starvation counter width; holds STARVE_MAX up to 15
    localparam int unsigned STARVE_CW = 4;

endpackage

// File: rtl/r200_mem_arb_if.sv
// r200_mem_arb_if: requester (IF, MEM) and memory-macro signals of the arbiter.
// slave  = arbiter side, master = pipeline/memory side.
interface r200_mem_arb_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    // instruction fetch
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    // data memory stage
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    // memory macro
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_rvalid;
    // pipeline control
    logic          stall_if;
    logic          stall_mem;
    logic          bus_err;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_rvalid,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               m_req, m_we, m_addr, m_wdata, stall_if, stall_mem, bus_err
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_rvalid,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               m_req, m_we, m_addr, m_wdata, stall_if, stall_mem, bus_err
    );

endinterface

// File: rtl/r200_mem_arb_starve_cnt.sv
// r200_mem_arb_starve_cnt: saturating count of MEM grants taken while IF waits.
// sat tells the arbiter to let IF win the next arbitration.
module r200_mem_arb_starve_cnt
    import r200_mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    logic [STARVE_CW-1:0] cnt_q;

    // Count MEM grants against a waiting IF; clear takes priority, hold at max
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && !sat) begin
            cnt_q <= cnt_q + STARVE_CW'(1);
        end
    end

    assign sat = (cnt_q >= STARVE_CW'(STARVE_MAX));

endmodule

// File: rtl/r200_mem_arb.sv
// r200_mem_arb: single-outstanding arbiter between IF and MEM for the shared
// memory macro. MEM wins unless IF has been starved STARVE_MAX times.
// Optional: define ARB_TIMEOUT_EN to abort a BUSY state after TIMEOUT cycles
// without m_rvalid (returns ARB_NOP and pulses bus_err).
module r200_mem_arb
    import r200_mem_arb_pkg::*;
#(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic          clk,
    input  logic          rst,
    r200_mem_arb_if.slave bus
);

    arb_state_t    state_q, state_d;
    logic          d_win, d_issue, i_issue;
    logic          starve_sat;
    logic          we_q;
    logic          tmo_hit;
    logic [AW-1:0] addr_c;

    if (STARVE_MAX < 1 || STARVE_MAX > 15 || TIMEOUT < 1) begin : g_cfg_chk
        $error("r200_mem_arb: STARVE_MAX must be 1..15 and TIMEOUT >= 1");
    end

    // Issue is only possible from IDLE and never while reset is held
    assign d_win   = bus.d_req & (~bus.if_req | ~starve_sat);
    assign d_issue = (state_q == ARB_IDLE) & rst & d_win;
    assign i_issue = (state_q == ARB_IDLE) & rst & ~d_win & bus.if_req;

    r200_mem_arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk (clk),
        .rst (rst),
        .inc (d_issue & bus.if_req),
        .clr (i_issue | ~bus.if_req),
        .sat (starve_sat)
    );

    // State register; reset drops any outstanding transaction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Remember whether the MEM transaction in flight is a write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q <= 1'b0;
        end else if (d_issue) begin
            we_q <= bus.d_we;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q;

    // Cycles spent waiting in BUSY; restarts whenever the FSM is idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_q <= '0;
        end else if (state_q == ARB_IDLE) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TW'(1);
        end
    end

    assign tmo_hit = (state_q != ARB_IDLE) && (tmo_q == TW'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // Next state, memory issue and combinational response forwarding
    always_comb begin
        state_d       = state_q;
        addr_c        = '0;
        bus.if_gnt    = 1'b0;
        bus.if_rvalid = 1'b0;
        bus.if_rdata  = '0;
        bus.d_gnt     = 1'b0;
        bus.d_rvalid  = 1'b0;
        bus.d_rdata   = '0;
        bus.m_req     = 1'b0;
        bus.m_we      = 1'b0;
        bus.m_wdata   = '0;
        bus.bus_err   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (d_issue) begin
                    bus.d_gnt   = 1'b1;
                    bus.m_req   = 1'b1;
                    bus.m_we    = bus.d_we;
                    addr_c      = bus.d_addr;
                    bus.m_wdata = bus.d_wdata;
                    state_d     = ARB_BUSY_D;
                end else if (i_issue) begin
                    bus.if_gnt  = 1'b1;
                    bus.m_req   = 1'b1;
                    addr_c      = bus.if_addr;
                    state_d     = ARB_BUSY_I;
                end
            end
            ARB_BUSY_I: begin
                if (bus.m_rvalid) begin
                    bus.if_rvalid = 1'b1;
                    bus.if_rdata  = bus.m_rdata;
                    state_d       = ARB_IDLE;
                end else if (tmo_hit) begin
                    bus.if_rvalid = 1'b1;
                    bus.if_rdata  = DW'(ARB_NOP);
                    bus.bus_err   = 1'b1;
                    state_d       = ARB_IDLE;
                end
            end
            ARB_BUSY_D: begin
                if (bus.m_rvalid) begin
                    bus.d_rvalid = 1'b1;
                    bus.d_rdata  = we_q ? '0 : bus.m_rdata;
                    state_d      = ARB_IDLE;
                end else if (tmo_hit) begin
                    bus.d_rvalid = 1'b1;
                    bus.d_rdata  = we_q ? '0 : DW'(ARB_NOP);
                    bus.bus_err  = 1'b1;
                    state_d      = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign bus.m_addr    = addr_c;
    assign bus.stall_if  = bus.if_req & ~bus.if_rvalid;
    assign bus.stall_mem = bus.d_req & ~bus.d_rvalid;

endmodule

// File: tb/tb_r200_mem_arb.sv
// tb_r200_mem_arb: scoreboard bench for r200_mem_arb with a variable-latency
// memory model. Define ARB_TIMEOUT_EN to also cover the timeout abort.
module tb_r200_mem_arb;

    logic clk = 1'b0;
    logic rst;

    r200_mem_arb_if #(.AW(32), .DW(32)) bus ();

    r200_mem_arb #(
        .AW         (32),
        .DW         (32),
        .STARVE_MAX (4),
        .TIMEOUT    (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int unsigned cyc    = 0;
    int unsigned err_cnt = 0;
    int unsigned last_d_rv = 0;
    int unsigned last_i_gnt = 0;

    logic [31:0] if_q[$];
    logic [31:0] d_q[$];
    byte         gnt_log[$];
    int unsigned gnt_cyc[$];

    logic [31:0] mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];
    int unsigned mem_lat  = 2;
    bit          mem_mute = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0], 16'hA5C3};
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    always @(posedge clk) cyc++;

    // Memory macro: capture at negedge, answer mem_lat cycles after the issue cycle
    initial begin : mem_model
        int unsigned left;
        bit          busy;
        logic [31:0] a;
        busy = 1'b0;
        left = 0;
        a    = '0;
        bus.m_rvalid = 1'b0;
        bus.m_rdata  = '0;
        forever begin
            @(negedge clk);
            if (bus.m_req === 1'b1 && !mem_mute) begin
                busy = 1'b1;
                left = mem_lat;
                a    = bus.m_addr;
                if (bus.m_we) mem[a] = bus.m_wdata;
            end
            @(posedge clk);
            #2;
            bus.m_rvalid = 1'b0;
            bus.m_rdata  = '0;
            if (busy) begin
                left--;
                if (left == 0) begin
                    busy = 1'b0;
                    bus.m_rvalid = 1'b1;
                    bus.m_rdata  = mem.exists(a) ? mem[a] : dflt(a);
                end
            end
        end
    end

    // Response scoreboard and per-cycle protocol checks
    always @(negedge clk) begin : monitor
        if (bus.if_rvalid) begin
            if (if_q.size() == 0) chk("if_unexp", 32'(bus.if_rvalid), 32'd0);
            else                  chk("if_rdata", bus.if_rdata, if_q.pop_front());
        end
        if (bus.d_rvalid) begin
            last_d_rv = cyc;
            if (d_q.size() == 0) chk("d_unexp", 32'(bus.d_rvalid), 32'd0);
            else                 chk("d_rdata", bus.d_rdata, d_q.pop_front());
        end
        if (bus.if_rvalid && bus.d_rvalid) chk("rv_excl", 32'd1, 32'd0);
        if (bus.if_gnt || bus.d_gnt || bus.m_req) begin
            chk("m_req_gnt", 32'(bus.m_req), 32'(bus.if_gnt | bus.d_gnt));
            chk("gnt_excl", 32'(bus.if_gnt & bus.d_gnt), 32'd0);
            if (bus.d_gnt) begin
                chk("m_addr_d", bus.m_addr, bus.d_addr);
                chk("m_we_d", 32'(bus.m_we), 32'(bus.d_we));
                if (bus.d_we) chk("m_wdata", bus.m_wdata, bus.d_wdata);
                gnt_log.push_back(8'h44);
                gnt_cyc.push_back(cyc);
            end else if (bus.if_gnt) begin
                chk("m_addr_i", bus.m_addr, bus.if_addr);
                chk("m_we_i", 32'(bus.m_we), 32'd0);
                gnt_log.push_back(8'h49);
                last_i_gnt = cyc;
            end
        end
        if (bus.bus_err) err_cnt++;
    end

    task automatic wait_rv(input bit is_d);
        int unsigned n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 64) begin
            @(negedge clk);
            seen = is_d ? bus.d_rvalid : bus.if_rvalid;
            n++;
        end
        if (!seen) chk(is_d ? "d_rv_timeout" : "if_rv_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #2;
    endtask

    task automatic if_read(input logic [31:0] a);
        bus.if_req  = 1'b1;
        bus.if_addr = a;
        if_q.push_back(ref_rd(a));
        wait_rv(1'b0);
        bus.if_req = 1'b0;
    endtask

    task automatic d_access(input logic we, input logic [31:0] a, input logic [31:0] wd);
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_addr  = a;
        bus.d_wdata = wd;
        d_q.push_back(we ? 32'h0 : ref_rd(a));
        if (we) ref_mem[a] = wd;
        wait_rv(1'b1);
        bus.d_req = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        string pat;
        rst = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        mem[32'h100] = 32'h1234_5678;
        ref_mem[32'h100] = 32'h1234_5678;

        // Reset: outputs quiet, stalls follow requests, nothing issued
        repeat (2) @(posedge clk);
        #2;
        @(negedge clk);
        chk("rst_outs", 32'(|{bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.d_gnt, bus.d_rvalid,
                              bus.d_rdata, bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata, bus.bus_err}), 32'd0);
        chk("rst_stall_if0", 32'(bus.stall_if), 32'd0);
        @(posedge clk); #2;
        bus.if_req = 1'b1; bus.d_req = 1'b1; bus.d_addr = 32'h40; bus.if_addr = 32'h80;
        @(negedge clk);
        chk("rst_no_gnt", 32'(bus.if_gnt | bus.d_gnt | bus.m_req), 32'd0);
        chk("rst_stall_if", 32'(bus.stall_if), 32'd1);
        chk("rst_stall_mem", 32'(bus.stall_mem), 32'd1);
        @(posedge clk); #2;
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;

        // Lone IF read, latency 2
        mem_lat = 2;
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        if_q.push_back(ref_rd(32'h100));
        @(negedge clk);
        chk("t1_gnt_c0", 32'(bus.if_gnt), 32'd1);
        chk("t1_stall_c0", 32'(bus.stall_if), 32'd1);
        @(negedge clk);
        chk("t1_gnt_c1", 32'(bus.if_gnt), 32'd0);
        chk("t1_rv_c1", 32'(bus.if_rvalid), 32'd0);
        chk("t1_rdata_c1", bus.if_rdata, 32'd0);
        chk("t1_stall_c1", 32'(bus.stall_if), 32'd1);
        @(negedge clk);
        chk("t1_rv_c2", 32'(bus.if_rvalid), 32'd1);
        chk("t1_stall_c2", 32'(bus.stall_if), 32'd0);
        @(posedge clk); #2;
        bus.if_req = 1'b0;
        @(posedge clk); #2;

        // IF and MEM together: MEM write first, IF the cycle after d_rvalid
        gnt_log.delete();
        fork
            d_access(1'b1, 32'h200, 32'hCAFE_F00D);
            if_read(32'h104);
        join
        chk("t2_ngnt", gnt_log.size(), 32'd2);
        if (gnt_log.size() == 2) begin
            chk("t2_first", 32'(gnt_log[0]), 32'h44);
            chk("t2_second", 32'(gnt_log[1]), 32'h49);
        end
        chk("t2_if_after_d", last_i_gnt - last_d_rv, 32'd1);
        d_access(1'b0, 32'h200, 32'h0);
        if_read(32'h200);

        // Starvation: MEM back-to-back, IF forced through every 5th grant
        mem_lat = 1;
        gnt_log.delete();
        pat = "DDDDIDDDDID";
        fork
            for (int unsigned i = 0; i < 9; i++) d_access(1'b0, 32'h1000 + 4 * i, 32'h0);
            for (int unsigned i = 0; i < 2; i++) if_read(32'h2000 + 4 * i);
        join
        chk("t3_ngnt", gnt_log.size(), 32'd11);
        if (gnt_log.size() == 11) begin
            for (int unsigned i = 0; i < 11; i++) chk("t3_order", 32'(gnt_log[i]), 32'(pat[i]));
        end

        // Reset during BUSY_D; the late response must be ignored
        @(posedge clk); #2;
        mem_lat = 5;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h300;
        @(negedge clk);
        chk("t4_gnt", 32'(bus.d_gnt), 32'd1);
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        chk("t4_rst_gnt", 32'(bus.d_gnt | bus.m_req), 32'd0);
        chk("t4_rst_stall", 32'(bus.stall_mem), 32'd1);
        @(posedge clk); #2;
        bus.d_req = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        for (int unsigned i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t4_stray", 32'(bus.d_rvalid | bus.if_rvalid), 32'd0);
        end
        @(posedge clk); #2;
        mem_lat = 2;
        d_access(1'b0, 32'h304, 32'h0);

        // Back-to-back MEM reads at latency 1: one grant every 2 cycles
        mem_lat = 1;
        gnt_cyc.delete();
        for (int unsigned i = 0; i < 4; i++) d_access(1'b0, 32'h3000 + 4 * i, 32'h0);
        chk("t5_ngnt", gnt_cyc.size(), 32'd4);
        if (gnt_cyc.size() == 4) begin
            for (int unsigned i = 0; i < 3; i++) chk("t5_spacing", gnt_cyc[i + 1] - gnt_cyc[i], 32'd2);
        end

`ifdef ARB_TIMEOUT_EN
        // Memory never answers: abort 16 cycles after the grant
        begin : t6
            int unsigned n;
            mem_mute = 1'b1;
            bus.if_req = 1'b1; bus.if_addr = 32'h400;
            if_q.push_back(32'h0000_0013);
            @(negedge clk);
            chk("t6_gnt", 32'(bus.if_gnt), 32'd1);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus.if_rvalid && n < 40);
            chk("t6_latency", n, 32'd16);
            chk("t6_bus_err", 32'(bus.bus_err), 32'd1);
            @(posedge clk); #2;
            bus.if_req = 1'b0;
            @(negedge clk);
            chk("t6_err_pulse", 32'(bus.bus_err), 32'd0);
            mem_mute = 1'b0;
            @(posedge clk); #2;
        end
        chk("bus_err_cnt", err_cnt, 32'd1);
`else
        chk("bus_err_cnt", err_cnt, 32'd0);
`endif

        repeat (3) @(posedge clk);
        chk("if_q_left", if_q.size(), 32'd0);
        chk("d_q_left", d_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
